// File: rtl/apb_cmd_master.sv
// APB4 master: queues valid/ready commands in a small FIFO, issues them in order as
// APB transfers with a bounded access phase, and returns one response per command.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_strb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0]   cmd_level,
  output logic                         busy,
  output logic                         m_psel,
  output logic                         m_penable,
  output logic                         m_pwrite,
  output logic [ADDR_W-1:0]            m_paddr,
  output logic [DATA_W-1:0]            m_pwdata,
  output logic [DATA_W/8-1:0]          m_pstrb,
  input  logic                         m_pready,
  input  logic                         m_pslverr,
  input  logic [DATA_W-1:0]            m_prdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_to_q, rsp_to_d;
  logic                push, pop, full, empty;

  logic                wr_mem_q   [DEPTH];
  logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
  logic [DATA_W-1:0]   data_mem_q [DEPTH];
  logic [STRB_W-1:0]   strb_mem_q [DEPTH];

  logic                head_wr;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [STRB_W-1:0]   head_strb;

  assign full      = (level_q == LVL_MAX);
  assign empty     = (level_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign cmd_level = level_q;
  assign busy      = (state_q != IDLE) || !empty;

  assign head_wr   = wr_mem_q[rd_ptr_q];
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign head_strb = strb_mem_q[rd_ptr_q];

  always_ff @(posedge sys_clk) begin
    if (push) begin
      wr_mem_q[wr_ptr_q]   <= cmd_write;
      addr_mem_q[wr_ptr_q] <= cmd_addr;
      data_mem_q[wr_ptr_q] <= cmd_wdata;
      strb_mem_q[wr_ptr_q] <= cmd_strb;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      wait_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q     <= level_d;
      state_q     <= state_d;
      wait_q      <= wait_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    m_psel      = 1'b0;
    m_penable   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SETUP;
          wait_d  = '0;
        end
      end
      SETUP: begin
        m_psel  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        if (m_pready) begin
          pop         = 1'b1;
          rsp_rdata_d = head_wr ? '0 : m_prdata;
          rsp_err_d   = m_pslverr;
          rsp_to_d    = 1'b0;
          state_d     = RESP;
        end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
          // Abort on the last permitted access cycle; the slave's late answer is ignored.
          pop         = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB fields come straight from the FIFO head, which cannot move until the pop.
  assign m_pwrite    = m_psel && head_wr;
  assign m_paddr     = m_psel ? head_addr : '0;
  assign m_pwdata    = (m_psel && head_wr) ? head_data : '0;
  assign m_pstrb     = (m_psel && head_wr) ? head_strb : '0;

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus a randomized command stream, with an
// APB slave and expected responses derived from per-command plans held in queues.
module tb_apb_cmd_master;

  localparam int unsigned AW      = 12;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LW      = $clog2(DEPTH + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [LW-1:0] cmd_level;
  logic          busy;
  logic          m_psel, m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [SW-1:0] m_pstrb;
  logic          m_pready = 1'b0;
  logic          m_pslverr = 1'b0;
  logic [DW-1:0] m_prdata = '0;

  always #5 sys_clk = ~sys_clk;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .cmd_level(cmd_level), .busy(busy),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int unsigned   waits;
    logic          slverr;
    logic [DW-1:0] rdata;
    logic          e_err;
    logic          e_to;
    logic [DW-1:0] e_rdata;
  } plan_t;

  plan_t       plan_q[$];
  plan_t       exp_q[$];
  plan_t       cur;
  int unsigned acc_cnt  = 0;
  int unsigned last_acc = 0;
  int unsigned n_act    = 0;
  int unsigned n_cmp    = 0;
  int unsigned n_mis    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The reference: a transfer times out iff the slave would need more than TIMEOUT access cycles.
  function automatic plan_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [SW-1:0] st, input int unsigned waits,
                               input logic se, input logic [DW-1:0] rd);
    plan_t p;
    p.wr = wr; p.addr = a; p.wdata = wd; p.strb = st;
    p.waits = waits; p.slverr = se; p.rdata = rd;
    p.e_to    = (TIMEOUT != 0) && (waits >= TIMEOUT);
    p.e_err   = p.e_to || se;
    p.e_rdata = (wr || p.e_to) ? '0 : rd;
    return p;
  endfunction

  task automatic fields(input string tag);
    check({tag, "_paddr"},  64'(m_paddr),  64'(cur.addr));
    check({tag, "_pwrite"}, 64'(m_pwrite), 64'(cur.wr));
    check({tag, "_pwdata"}, 64'(m_pwdata), cur.wr ? 64'(cur.wdata) : 64'd0);
    check({tag, "_pstrb"},  64'(m_pstrb),  cur.wr ? 64'(cur.strb) : 64'd0);
  endtask

  // One clock: score the response handshake that completes at this edge, then play the slave.
  task automatic tick();
    plan_t e;
    if (!sys_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        check("rsp_rdata",   64'(rsp_rdata),   64'(e.e_rdata));
        check("rsp_err",     64'(rsp_err),     64'(e.e_err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.e_to));
      end
    end
    @(posedge sys_clk);
    #1;
    if (m_psel) n_act++;
    m_pready  = 1'b0;
    m_pslverr = 1'($urandom_range(0, 1));
    m_prdata  = $urandom;
    if (m_psel && !m_penable) begin
      if (plan_q.size() == 0) check("setup_unexpected", 64'(plan_q.size()), 64'd1);
      else begin
        cur = plan_q.pop_front();
        acc_cnt = 0;
        fields("setup");
      end
    end else if (m_psel && m_penable) begin
      fields("access");
      if (acc_cnt == cur.waits) begin
        m_pready  = 1'b1;
        m_prdata  = cur.rdata;
        m_pslverr = cur.slverr;
      end
      acc_cnt++;
      last_acc = acc_cnt;
    end
  endtask

  task automatic push(input plan_t p, input bit rnd, input int unsigned max_wait);
    int unsigned n = 0;
    plan_q.push_back(p);
    exp_q.push_back(p);
    cmd_valid = 1'b1; cmd_write = p.wr; cmd_addr = p.addr;
    cmd_wdata = p.wdata; cmd_strb = p.strb;
    while (!cmd_ready && n < max_wait) begin
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check("push_accepted", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int unsigned max_cyc);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int unsigned   r, w;
    sys_rst = 1'b1;
    tick();
    tick();
    check("rst_psel",    64'(m_psel),    64'd0);
    check("rst_penable", 64'(m_penable), 64'd0);
    check("rst_pwrite",  64'(m_pwrite),  64'd0);
    check("rst_paddr",   64'(m_paddr),   64'd0);
    check("rst_pwdata",  64'(m_pwdata),  64'd0);
    check("rst_pstrb",   64'(m_pstrb),   64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_rsp_to",    64'(rsp_timeout), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_level",   64'(cmd_level), 64'd0);
    check("rst_ready",   64'(cmd_ready), 64'd1);
    check("rst_busy",    64'(busy),      64'd0);
    sys_rst = 1'b0;

    // Zero-wait write: exact cycle positions after the accepting edge k.
    push(mk(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h1111_2222), 1'b0, 5);
    check("t1_level_k", 64'(cmd_level), 64'd1);
    check("t1_psel_k",  64'(m_psel),    64'd0);
    tick();
    check("t1_psel_k1",    64'(m_psel),    64'd1);
    check("t1_penable_k1", 64'(m_penable), 64'd0);
    tick();
    check("t1_penable_k2", 64'(m_penable), 64'd1);
    check("t1_pwdata_k2",  64'(m_pwdata),  64'hDEADBEEF);
    check("t1_pstrb_k2",   64'(m_pstrb),   64'hF);
    check("t1_paddr_k2",   64'(m_paddr),   64'h004);
    tick();
    check("t1_psel_k3",  64'(m_psel),    64'd0);
    check("t1_rsp_k3",   64'(rsp_valid), 64'd1);
    drain("t1_drain", 10);

    // Read with two wait states; read masks wdata/strb on the bus.
    push(mk(1'b0, 12'h010, 32'hFFFF0000, 4'h5, 2, 1'b0, 32'h12345678), 1'b0, 5);
    drain("t2_drain", 20);
    check("t2_penable_cycles", 64'(last_acc), 64'd3);

    // Slave error, then a following command must still run.
    push(mk(1'b1, 12'h0FF, 32'hCAFEF00D, 4'h3, 0, 1'b1, 32'h0), 1'b0, 5);
    push(mk(1'b0, 12'h100, 32'h0, 4'hF, 1, 1'b0, 32'hA5A5A5A5), 1'b0, 20);
    drain("t3_drain", 30);

    // Answer on the last permitted access cycle: no timeout.
    push(mk(1'b0, 12'h030, 32'h0, 4'h0, TIMEOUT - 1, 1'b1, 32'h0BADF00D), 1'b0, 5);
    drain("t4a_drain", 40);
    check("t4a_penable_cycles", 64'(last_acc), 64'(TIMEOUT));

    // Stuck slave: aborted after exactly TIMEOUT access cycles.
    push(mk(1'b0, 12'h020, 32'hFFFFFFFF, 4'hF, 1000, 1'b0, 32'h55555555), 1'b0, 5);
    drain("t4b_drain", 40);
    check("t4b_penable_cycles", 64'(last_acc), 64'(TIMEOUT));
    check("t4b_psel_after", 64'(m_psel), 64'd0);

    // Fill with responses blocked.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(mk(1'b0, AW'(12'h200 + 4 * i), 32'h0, 4'h0, 0, 1'b0, DW'(32'h7000 + i)), 1'b0, 20);
    tick(); tick(); tick();
    check("t5_level_full", 64'(cmd_level), 64'(DEPTH));
    check("t5_ready_low",  64'(cmd_ready), 64'd0);
    check("t5_rsp_wait",   64'(rsp_valid), 64'd1);
    check("t5_psel_idle",  64'(m_psel),    64'd0);
    check("t5_busy",       64'(busy),      64'd1);
    rsp_ready = 1'b1;
    push(mk(1'b1, 12'h300, 32'h600D600D, 4'h9, 0, 1'b0, 32'h0), 1'b0, 50);
    drain("t5_drain", 200);

    // Randomized stream.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      w = (r == 9) ? (TIMEOUT + $urandom_range(0, 4)) : (r == 8) ? TIMEOUT - 1 : $urandom_range(0, 3);
      ra = AW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      push(mk(1'($urandom_range(0, 1)), ra, $urandom, SW'($urandom), w,
              1'($urandom_range(0, 1)), $urandom), 1'b1, 500);
    end
    rsp_ready = 1'b1;
    drain("rnd_drain", 2000);

    // Reset during ACCESS with three commands in the FIFO.
    push(mk(1'b0, 12'h040, 32'h0, 4'h0, 1000, 1'b0, 32'h1), 1'b0, 5);
    push(mk(1'b1, 12'h044, 32'h2, 4'hF, 0, 1'b0, 32'h0), 1'b0, 5);
    push(mk(1'b1, 12'h048, 32'h3, 4'hF, 0, 1'b0, 32'h0), 1'b0, 5);
    for (int i = 0; i < 10 && !(m_psel && m_penable); i++) tick();
    tick();
    check("t6_in_access", 64'(m_penable), 64'd1);
    check("t6_level",     64'(cmd_level), 64'd3);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("t6_psel",      64'(m_psel),    64'd0);
    check("t6_penable",   64'(m_penable), 64'd0);
    check("t6_level_rst", 64'(cmd_level), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_ready",     64'(cmd_ready), 64'd1);
    plan_q.delete();
    exp_q.delete();
    n_act = 0;
    repeat (20) tick();
    check("t6_no_apb",  64'(n_act), 64'd0);
    check("t6_idle",    64'(busy),  64'd0);
    check("t6_no_rsp",  64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Synthesizable APB4 master that turns a valid/ready command stream into APB write/read transfers and returns one response per command. It buffers up to DEPTH commands, runs them strictly in order, and bounds every access phase with a wait-state timeout. It sits between on-chip control logic (sequencers, self-test engines) and APB slaves such as the 64-bit timer. Address, data and strobe widths, FIFO depth and timeout are parametrised.

## Interface
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; must be a multiple of 8.
- DEPTH, 4, command FIFO entries; must be a power of two, ≥2.
- TIMEOUT, 16, maximum access-phase cycles before abort; 0 disables the timeout.
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  transfer aborted by the timeout.
- cmd_level  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  FSM not in IDLE or FIFO not empty.
- m_psel, m_penable, m_pwrite  out  1  APB controls.
- m_paddr  out  ADDR_W; m_pwdata  out  DATA_W; m_pstrb  out  DATA_W/8.
- m_pready, m_pslverr  in  1; m_prdata  in  DATA_W.

## Operation
- Push on cmd_valid && cmd_ready. Pop when the head transfer completes or is aborted. No push when full, even if a pop occurs in the same cycle. A push and a pop in the same cycle leave the level unchanged.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if the FIFO is non-empty, go to SETUP and drive m_psel=1, m_penable=0, with the APB fields taken from the FIFO head.
- SETUP: always go to ACCESS after one cycle, with m_penable=1. The APB fields stay stable.
- ACCESS with m_pready=1: capture m_prdata (reads only), set rsp_err=m_pslverr, pop the FIFO, drop m_psel/m_penable, go to RESP.
- ACCESS with m_pready=0: increment the wait counter. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with m_pready still 0, abort: drop m_psel/m_penable, pop the FIFO, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
- RESP: hold rsp_valid=1 and the response fields until rsp_ready=1, then go to IDLE.
- Read transfers drive m_pstrb=0 and m_pwdata=0. Write responses return rsp_rdata=0.
- m_pslverr is sampled only when m_pready=1 in ACCESS.

## Timing
- Reset (sync, sys_rst=1 at an edge) applies from that edge:
  - All m_* outputs are 0.
  - rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0.
  - FIFO is emptied and cmd_level=0.
  - cmd_ready=1 and busy=0.
  - FSM is in IDLE.
- Reset mid-transfer drops m_psel/m_penable at the same edge; no response is generated.
- Command accepted at edge k with the FIFO previously empty and FSM in IDLE:
  - m_psel=1 after edge k+1.
  - m_penable=1 after edge k+2.
  - With zero wait states, completion happens at edge k+3: m_psel=0 and rsp_valid=1 after k+3.
- Each wait state adds one cycle. The access phase lasts at most TIMEOUT cycles. The wait counter clears on entry to SETUP.
- With rsp_ready held at 1, the next transfer's SETUP starts 2 cycles after completion (RESP, then IDLE). Minimum period is 4 cycles per transfer.
- cmd_level updates the cycle after the push or pop. cmd_ready deasserts the cycle after the DEPTH-th push.

## Test plan
- Write 0x004, data 0xDEADBEEF, strb 0xF, pready=1 → psel at k+1, penable at k+2 with paddr 0x004, pwdata 0xDEADBEEF, pstrb 0xF; rsp_valid at k+3 with rsp_err=0, rsp_rdata=0.
- Read 0x010, slave holds pready=0 for 2 cycles and returns prdata 0x12345678 → penable high 3 cycles, pstrb=0; rsp_rdata 0x12345678, rsp_err=0.
- Write 0x0FF, slave returns pready=1 with pslverr=1 → rsp_err=1, rsp_timeout=0; next command still executes.
- Read 0x020 with pready stuck at 0, TIMEOUT=16 → penable high exactly 16 cycles, then psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Push 6 commands back-to-back with rsp_ready=0, DEPTH=4 → cmd_ready=0 while cmd_level=4; first transfer waits in RESP; with rsp_ready=1, all 6 responses return in order.
- Assert sys_rst for 1 cycle during ACCESS with 3 commands queued → next edge: psel=penable=0, cmd_level=0, rsp_valid=0, no APB activity afterwards.
